text_cursor_ctrl: RTL
=====================

// Module: text_cursor_ctrl
// PURPOSE
//  2-D cursor controller for the text display. Converts held left/right/up/down move
//  commands into a registered (col,row) position and a linear cell index.
//  Steps once on each press, then auto-repeats after a hold delay. Edge behaviour is
//  selectable per instance. Sits between the input decode logic and the char/pixel
//  addressing logic. Generalises the 1-D saturating pixel counter.
// PARAMETERS
//  COLS          80  cells per row, >=2
//  ROWS          30  rows, >=2
//  WRAP_MODE     0   0=saturate at edges; 1=wrap within axis; 2=line-wrap (col carries into row, screen wraps)
//  REPEAT_DELAY  25  cycles from press to first repeat step; 0 = no auto-repeat
//  REPEAT_RATE   5   cycles between repeat steps, >=1
// PORTS
//  clk     in   1      system clock, all logic posedge
//  rst_n   in   1      synchronous active-low reset
//  move_h  in   2      2'b10 = right (+1), 2'b01 = left (-1), 2'b00/2'b11 = no horizontal move
//  move_v  in   2      2'b10 = down (+1), 2'b01 = up (-1), 2'b00/2'b11 = no vertical move
//  home    in   1      force cursor to (0,0)
//  col     out  COL_W  current column, COL_W = $clog2(COLS)
//  row     out  ROW_W  current row, ROW_W = $clog2(ROWS)
//  index   out  IDX_W  row*COLS+col, IDX_W = $clog2(COLS*ROWS)
//  moved   out  1      1-cycle pulse when col/row changed on this edge
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): col=row=index=0, moved=0, repeat FSM=IDLE; overrides all inputs.
//  - cmd = {move_h,move_v}. An encoding of 11 on an axis is treated as 00.
//    cmd is active when either axis is INC or DEC.
//  - Repeat FSM, sub-module output step:
//      IDLE:   active cmd -> step=1, latch cmd, go to DELAY (cnt=0).
//      DELAY:  cmd inactive -> IDLE. cmd differs from latched -> new press: step=1, relatch, cnt=0.
//              cnt==REPEAT_DELAY-1 -> step=1, go to REPEAT (cnt=0).
//      REPEAT: same exits as DELAY. cnt==REPEAT_RATE-1 -> step=1, cnt=0.
//      REPEAT_DELAY=0: FSM never leaves DELAY on time; exactly one step per press.
//    Net effect: steps at press-relative cycles 0, D, D+R, D+2R, ...
//  - Position update: registered on the same edge step=1 is sampled (1-cycle latency from cmd to col).
//    Both axes are applied in the same step.
//  - WRAP_MODE 0: inc at max / dec at 0 holds that axis (no change, no moved).
//  - WRAP_MODE 1: col wraps COLS-1<->0 with row unchanged; row wraps ROWS-1<->0.
//  - WRAP_MODE 2: horizontal overflow/underflow gives carry c in {-1,0,+1}.
//    row_next = (row + v + c) mod ROWS, where v is the vertical step.
//    (COLS-1,ROWS-1) right -> (0,0); (0,0) left -> (COLS-1,ROWS-1).
//  - home: highest priority after reset. Next edge gives (0,0) and FSM=IDLE.
//    A cmd still held the cycle after home deasserts is a new press.
//  - moved=1 iff registered (col,row) differs from the previous value. Home at (0,0) -> moved=0.
//  - index is updated on the same edge as col/row and always equals row*COLS+col.
//    Compute it from next-state values. A constant multiply is allowed.
//  - Arithmetic: use one extra bit for +1/-1 compares; never let col>=COLS or row>=ROWS.
//    For non-power-of-2 sizes, wrap by compare, not modulo truncation.
//  - Counter width: $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
// STRUCTURE
//  - text_disp_pkg: MV_HOLD=2'b00, MV_DEC=2'b01, MV_INC=2'b10; WRAP_SAT=0, WRAP_AXIS=1, WRAP_LINE=2;
//    repeat FSM state enum (IDLE, DELAY, REPEAT).
//  - Sub-module key_repeat_gen (clk, rst_n, cmd[3:0], clr, step): FSM + counter. clr is driven by home.
//  - Top level: next-position datapath, wrap select via generate on WRAP_MODE, output registers.
// TESTING  (COLS=4, ROWS=3, REPEAT_DELAY=3, REPEAT_RATE=2 unless noted)
//  1. rst_n=0 for 2 cycles with move_h=10 held -> col=row=index=0, moved=0; first step only after release.
//  2. MODE0, 1-cycle right pulses x5 from (0,0) -> col 1,2,3,3,3; moved on the first 3 only. Left at col0 -> no change.
//  3. COLS=8, hold move_h=10 for 10 cycles from col0 -> steps at rel. cycles 0,3,5,7,9; col ends at 5.
//     Release then hold move_h=01 -> immediate step to 4.
//  4. MODE2: (3,0)+right -> (0,1), index 4. (3,2)+right -> (0,0). (0,0)+left -> (3,2), index 11.
//     (3,0)+right+down in the same cycle -> (0,2).
//  5. MODE1: (3,1)+right -> (0,1), index 4. (2,0)+up -> (2,2), index 10. Held cmd changes 10->01 -> immediate opposite step.
//  6. Mid-repeat at (2,1): home -> (0,0), moved=1, FSM IDLE. home at (0,0) -> moved=0.
//     rst_n=0 mid-hold -> zeros; cmd 11/11 -> never steps.

Source files
------------

// File: rtl/text_disp_pkg.sv
// rtl/text_disp_pkg.sv - shared move encodings, wrap modes and repeat FSM states
// Purpose: constants and helpers used by the text cursor controller and key repeat generator.
// Contents: MV_* axis move codes, WRAP_* edge modes, rpt_state_e, mv_norm().
package text_disp_pkg;

  localparam logic [1:0] MV_HOLD = 2'b00;
  localparam logic [1:0] MV_DEC  = 2'b01;
  localparam logic [1:0] MV_INC  = 2'b10;

  localparam int WRAP_SAT  = 0;
  localparam int WRAP_AXIS = 1;
  localparam int WRAP_LINE = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Both direction bits set on one axis means "no move" on that axis.
  function automatic logic [1:0] mv_norm(input logic [1:0] m);
    return (m == 2'b11) ? MV_HOLD : m;
  endfunction

endpackage

// File: rtl/key_repeat_gen.sv
// rtl/key_repeat_gen.sv - press/hold auto-repeat step generator
// Purpose: emits a one-cycle step on a new press, then after REPEAT_DELAY cycles
//          and every REPEAT_RATE cycles thereafter while the same command is held.
// Ports: clk, rst_n (sync active-low), cmd[3:0] normalized {h,v} command,
//        clr (forces IDLE, suppresses step), step (combinational step strobe).
module key_repeat_gen
  import text_disp_pkg::*;
#(
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5,
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd,
  input  logic       clr,
  output logic       step
);

  localparam logic [CNT_W-1:0] D_LAST = (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_RATE - 1);

  rpt_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       latched, latched_n;
  logic             active;

  assign active = (cmd != 4'b0000);

  always_comb begin
    step      = 1'b0;
    state_n   = state;
    cnt_n     = cnt;
    latched_n = latched;
    if (clr) begin
      state_n = RPT_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (active) begin
            step      = 1'b1;
            latched_n = cmd;
            state_n   = RPT_DELAY;
            cnt_n     = '0;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (!active) begin
            state_n = RPT_IDLE;
            cnt_n   = '0;
          end else if (cmd != latched) begin
            // A different held command counts as a fresh press.
            step      = 1'b1;
            latched_n = cmd;
            state_n   = RPT_DELAY;
            cnt_n     = '0;
          end else if (state == RPT_DELAY) begin
            // With no hold delay the FSM parks here: one step per press.
            if (REPEAT_DELAY > 0) begin
              if (cnt == D_LAST) begin
                step    = 1'b1;
                state_n = RPT_REPEAT;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
          end else begin
            if (cnt == R_LAST) begin
              step  = 1'b1;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = RPT_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RPT_IDLE;
      cnt     <= '0;
      latched <= 4'b0000;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      latched <= latched_n;
    end
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - 2-D text cursor with auto-repeat and selectable edge wrap
// Purpose: turns held move commands into a registered (col,row) position and linear index.
// Ports: clk, rst_n (sync active-low), move_h[1:0], move_v[1:0] (10=+1, 01=-1),
//        home (force (0,0)), col, row, index = row*COLS+col, moved (position changed pulse).
module text_cursor_ctrl
  import text_disp_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int WRAP_MODE    = 0,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS),
  localparam int IDX_W = $clog2(COLS * ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       move_h,
  input  logic [1:0]       move_v,
  input  logic             home,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [IDX_W-1:0] index,
  output logic             moved
);

  localparam logic [COL_W:0] COL_LAST = (COL_W + 1)'(COLS - 1);
  localparam logic [ROW_W:0] ROW_LAST = (ROW_W + 1)'(ROWS - 1);

  logic [1:0]       mh, mv;
  logic             inc_h, dec_h, inc_v, dec_v;
  logic             step;
  logic [COL_W-1:0] col_nx;
  logic [ROW_W-1:0] row_nx;
  logic [IDX_W-1:0] index_nx;

  assign mh    = mv_norm(move_h);
  assign mv    = mv_norm(move_v);
  assign inc_h = (mh == MV_INC);
  assign dec_h = (mh == MV_DEC);
  assign inc_v = (mv == MV_INC);
  assign dec_v = (mv == MV_DEC);

  key_repeat_gen #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rpt (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   ({mh, mv}),
    .clr   (home),
    .step  (step)
  );

  // +/-1 on one axis; the extra bit keeps the edge compare free of overflow,
  // and the edge is detected by compare so non-power-of-2 sizes wrap correctly.
  function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] c,
                                                input logic inc, input logic dec,
                                                input logic wrap);
    logic [COL_W:0] cx;
    cx = {1'b0, c};
    if (inc) begin
      if (cx == COL_LAST) return wrap ? '0 : c;
      cx = cx + 1'b1;
      return cx[COL_W-1:0];
    end else if (dec) begin
      if (cx == '0) return wrap ? COL_LAST[COL_W-1:0] : c;
      cx = cx - 1'b1;
      return cx[COL_W-1:0];
    end
    return c;
  endfunction

  function automatic logic [ROW_W-1:0] row_step(input logic [ROW_W-1:0] r,
                                                input logic inc, input logic dec,
                                                input logic wrap);
    logic [ROW_W:0] rx;
    rx = {1'b0, r};
    if (inc) begin
      if (rx == ROW_LAST) return wrap ? '0 : r;
      rx = rx + 1'b1;
      return rx[ROW_W-1:0];
    end else if (dec) begin
      if (rx == '0) return wrap ? ROW_LAST[ROW_W-1:0] : r;
      rx = rx - 1'b1;
      return rx[ROW_W-1:0];
    end
    return r;
  endfunction

  assign col_nx = col_step(col, inc_h, dec_h, (WRAP_MODE != WRAP_SAT));

  generate
    if (WRAP_MODE == WRAP_LINE) begin : g_line
      logic carry_up, carry_dn;
      // Column wrap carries into the row; applying carry and vertical step as
      // two chained wrapped +/-1 steps gives (row + v + c) mod ROWS.
      assign carry_up = inc_h && ({1'b0, col} == COL_LAST);
      assign carry_dn = dec_h && (col == '0);
      assign row_nx   = row_step(row_step(row, carry_up, carry_dn, 1'b1), inc_v, dec_v, 1'b1);
    end else begin : g_axis
      assign row_nx = row_step(row, inc_v, dec_v, (WRAP_MODE == WRAP_AXIS));
    end
  endgenerate

  assign index_nx = IDX_W'(int'(row_nx) * COLS + int'(col_nx));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      index <= '0;
      moved <= 1'b0;
    end else if (home) begin
      col   <= '0;
      row   <= '0;
      index <= '0;
      moved <= (col != '0) || (row != '0);
    end else if (step) begin
      col   <= col_nx;
      row   <= row_nx;
      index <= index_nx;
      moved <= (col_nx != col) || (row_nx != row);
    end else begin
      moved <= 1'b0;
    end
  end

endmodule
